// File: rtl/port_sweep_checker.sv
// port_sweep_checker
// Exhaustively sweeps a 4-bit x 4-bit combinational DUT: drives every {in1,in2}
// pair from 8'h00 to 8'hFF, waits SETTLE cycles, and compares dut_out with a
// selectable reference function. Reports mismatch count and first failing vector.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   i_start         one-cycle pulse, starts a sweep from IDLE or DONE
//   i_fn_sel        reference function select, latched at start
//   i_fn_sel_valid  when low at start, FN_SEL_DEFAULT is latched instead
//   i_dut_out       DUT response under check
//   o_in1, o_in2    registered stimulus operands
//   o_busy          high while driving/waiting
//   o_done          high in DONE
//   o_pass          high in DONE when no mismatch was seen
//   o_err_count     mismatching vectors in the current or last sweep
//   o_first_fail    {in1,in2} of the first mismatching vector
//
// Optional feature: define PORT_SWEEP_STOP_ON_FAIL_EN to end the sweep at the
// first mismatch (err_count = 1, pass = 0).
module port_sweep_checker #(
   parameter int unsigned SETTLE         = 1,
   parameter logic [1:0]  FN_SEL_DEFAULT = 2'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_start,
   input  logic [1:0] i_fn_sel,
   input  logic       i_fn_sel_valid,
   input  logic [3:0] i_dut_out,
   output logic [3:0] o_in1,
   output logic [3:0] o_in2,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_pass,
   output logic [8:0] o_err_count,
   output logic [7:0] o_first_fail
);

   localparam logic [3:0] SettleCnt = 4'(SETTLE);

   typedef enum logic [1:0] {StIdle, StDrive, StWait, StDone} state_e;

   state_e     r_state, w_state_next;
   logic [7:0] r_vec, w_vec_next;
   logic [1:0] r_fn, w_fn_next;
   logic [3:0] r_in1, w_in1_next;
   logic [3:0] r_in2, w_in2_next;
   logic [3:0] r_wait, w_wait_next;
   logic [8:0] r_err, w_err_next;
   logic [7:0] r_ff, w_ff_next;

   logic [3:0] w_expect;
   logic       w_sample;
   logic       w_mismatch;
   logic       w_last;

   function automatic logic [3:0] ref_fn(input logic [1:0] fn, input logic [3:0] a,
                                         input logic [3:0] b);
      logic [3:0] res;
      case (fn)
         2'd0:    res = a[1] ? (a ^ b) : (a & b);
         2'd1:    res = a[0] ? (a | b) : (a & b);
         2'd2:    res = a[2] ? (a ^ b) : (a & b);
         default: res = ~(a[2] ? (a ^ b) : (a & b));
      endcase
      return res;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_vec   <= 8'd0;
         r_fn    <= FN_SEL_DEFAULT;
         r_in1   <= 4'd0;
         r_in2   <= 4'd0;
         r_wait  <= 4'd0;
         r_err   <= 9'd0;
         r_ff    <= 8'd0;
      end else begin
         r_state <= w_state_next;
         r_vec   <= w_vec_next;
         r_fn    <= w_fn_next;
         r_in1   <= w_in1_next;
         r_in2   <= w_in2_next;
         r_wait  <= w_wait_next;
         r_err   <= w_err_next;
         r_ff    <= w_ff_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_vec_next   = r_vec;
      w_fn_next    = r_fn;
      w_in1_next   = r_in1;
      w_in2_next   = r_in2;
      w_wait_next  = r_wait;
      w_err_next   = r_err;
      w_ff_next    = r_ff;

      w_expect   = ref_fn(r_fn, r_in1, r_in2);
      // Counter value 1 marks the cycle SETTLE cycles after the operands changed.
      w_sample   = (r_state == StWait) && (r_wait == 4'd1);
      w_mismatch = w_sample && (i_dut_out != w_expect);
`ifdef PORT_SWEEP_STOP_ON_FAIL_EN
      w_last     = (r_vec == 8'hFF) || w_mismatch;
`else
      w_last     = (r_vec == 8'hFF);
`endif

      case (r_state)
         StIdle, StDone: begin
            if (i_start) begin
               w_state_next = StDrive;
               w_vec_next   = 8'd0;
               w_err_next   = 9'd0;
               w_ff_next    = 8'd0;
               w_fn_next    = i_fn_sel_valid ? i_fn_sel : FN_SEL_DEFAULT;
            end
         end
         StDrive: begin
            w_in1_next   = r_vec[7:4];
            w_in2_next   = r_vec[3:0];
            w_wait_next  = SettleCnt;
            w_state_next = StWait;
         end
         StWait: begin
            if (w_sample) begin
               if (w_mismatch) begin
                  w_err_next = r_err + 9'd1;
                  if (r_err == 9'd0) begin
                     w_ff_next = {r_in1, r_in2};
                  end
               end
               if (w_last) begin
                  w_state_next = StDone;
               end else begin
                  w_vec_next   = r_vec + 8'd1;
                  w_state_next = StDrive;
               end
            end else begin
               w_wait_next = r_wait - 4'd1;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   assign o_in1        = r_in1;
   assign o_in2        = r_in2;
   assign o_busy       = (r_state == StDrive) || (r_state == StWait);
   assign o_done       = (r_state == StDone);
   assign o_pass       = (r_state == StDone) && (r_err == 9'd0);
   assign o_err_count  = r_err;
   assign o_first_fail = r_ff;

endmodule

// File: tb/tb_port_sweep_checker.sv
// Scoreboard bench for port_sweep_checker. Three checker instances:
//   inst 0: SETTLE=1 against a combinational DUT model with configurable faults
//   inst 1: SETTLE=3 against a DUT whose result is valid in the 3rd cycle
//   inst 2: SETTLE=2 against that same slow DUT (expected to report errors)
module tb_port_sweep_checker;

   typedef struct {
      int unsigned inst;
      int unsigned err;
      int unsigned ff;
      int unsigned pass;
      int unsigned cycles;
      int unsigned start_cyc;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned cyc   = 0;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [1:0] fn_sel       = 2'd0;
   logic       fn_sel_valid = 1'b0;

   // Fault configuration of the modelled DUT on instance 0
   logic [1:0]  dut_fn    = 2'd0;
   logic [3:0]  stuck0    = 4'd0;
   logic [3:0]  stuck1    = 4'd0;
   logic [3:0]  flip_bits = 4'd0;
   int unsigned flip_mod  = 0;
   logic [1:0]  pipe_fn   = 2'd0;

   logic [3:0] obs [256];

   logic       m_start = 1'b0, p3_start = 1'b0, p2_start = 1'b0;
   logic [3:0] m_dut_out, p3_dut_out, p2_dut_out;
   logic [3:0] m_in1, m_in2, p3_in1, p3_in2, p2_in1, p2_in2;
   logic       m_busy, m_done, m_pass, p3_busy, p3_done, p3_pass, p2_busy, p2_done, p2_pass;
   logic [8:0] m_err, p3_err, p2_err;
   logic [7:0] m_ff, p3_ff, p2_ff;

   // Function definitions written straight from the reference table
   function automatic logic [3:0] spec_fn(input logic [1:0] fn, input logic [3:0] a,
                                          input logic [3:0] b);
      logic       c;
      logic [3:0] r;
      if (fn == 2'd0) c = a[1];
      else if (fn == 2'd1) c = a[0];
      else c = a[2];
      if (!c) r = a & b;
      else if (fn == 2'd1) r = a | b;
      else r = a ^ b;
      if (fn == 2'd3) r = ~r;
      return r;
   endfunction

   function automatic logic [3:0] faulty(input logic [7:0] v, input logic [1:0] fn,
                                         input logic [3:0] s0, input logic [3:0] s1,
                                         input logic [3:0] fb, input int unsigned fm);
      logic [3:0] r;
      r = (spec_fn(fn, v[7:4], v[3:0]) & ~s0) | s1;
      if (fm != 0 && (int'(v) % fm) == 0) r = r ^ fb;
      return r;
   endfunction

   assign m_dut_out = faulty({m_in1, m_in2}, dut_fn, stuck0, stuck1, flip_bits, flip_mod);

   // Two register stages: result is valid in the 3rd cycle after the operands change.
   logic [3:0] p3_r1 = 4'd0, p3_r2 = 4'd0, p2_r1 = 4'd0, p2_r2 = 4'd0;
   always @(posedge clk) begin
      p3_r1 <= spec_fn(pipe_fn, p3_in1, p3_in2);
      p3_r2 <= p3_r1;
      p2_r1 <= spec_fn(pipe_fn, p2_in1, p2_in2);
      p2_r2 <= p2_r1;
   end
   assign p3_dut_out = p3_r2;
   assign p2_dut_out = p2_r2;

   port_sweep_checker #(.SETTLE(1), .FN_SEL_DEFAULT(2'd0)) u_dut (
      .clk(clk), .rst_n(rst_n), .i_start(m_start), .i_fn_sel(fn_sel),
      .i_fn_sel_valid(fn_sel_valid), .i_dut_out(m_dut_out), .o_in1(m_in1), .o_in2(m_in2),
      .o_busy(m_busy), .o_done(m_done), .o_pass(m_pass), .o_err_count(m_err),
      .o_first_fail(m_ff)
   );

   port_sweep_checker #(.SETTLE(3), .FN_SEL_DEFAULT(2'd0)) u_dut_s3 (
      .clk(clk), .rst_n(rst_n), .i_start(p3_start), .i_fn_sel(fn_sel),
      .i_fn_sel_valid(fn_sel_valid), .i_dut_out(p3_dut_out), .o_in1(p3_in1), .o_in2(p3_in2),
      .o_busy(p3_busy), .o_done(p3_done), .o_pass(p3_pass), .o_err_count(p3_err),
      .o_first_fail(p3_ff)
   );

   port_sweep_checker #(.SETTLE(2), .FN_SEL_DEFAULT(2'd0)) u_dut_s2 (
      .clk(clk), .rst_n(rst_n), .i_start(p2_start), .i_fn_sel(fn_sel),
      .i_fn_sel_valid(fn_sel_valid), .i_dut_out(p2_dut_out), .o_in1(p2_in1), .o_in2(p2_in2),
      .o_busy(p2_busy), .o_done(p2_done), .o_pass(p2_pass), .o_err_count(p2_err),
      .o_first_fail(p2_ff)
   );

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_in1"}, m_in1, 0);
      check({pfx, "_in2"}, m_in2, 0);
      check({pfx, "_busy"}, m_busy, 0);
      check({pfx, "_done"}, m_done, 0);
      check({pfx, "_pass"}, m_pass, 0);
      check({pfx, "_err_count"}, m_err, 0);
      check({pfx, "_first_fail"}, m_ff, 0);
   endtask

   // Reference model: walk all 256 vectors in order against the observed responses.
   task automatic build_exp(input int unsigned inst, input logic [1:0] chk_fn,
                            input int unsigned settle, output exp_t e);
      e.inst = inst; e.err = 0; e.ff = 0; e.start_cyc = 0;
      e.cycles = 256 * (settle + 1);
      for (int v = 0; v < 256; v++) begin
         if (obs[v] != spec_fn(chk_fn, 4'(v >> 4), 4'(v & 15))) begin
            if (e.err == 0) e.ff = v;
`ifdef PORT_SWEEP_STOP_ON_FAIL_EN
            if (e.err == 0) e.cycles = (v + 1) * (settle + 1);
`endif
            e.err = e.err + 1;
         end
      end
`ifdef PORT_SWEEP_STOP_ON_FAIL_EN
      if (e.err > 1) e.err = 1;
`endif
      e.pass = (e.err == 0) ? 1 : 0;
   endtask

   task automatic fill_main();
      for (int v = 0; v < 256; v++)
         obs[v] = faulty(8'(v), dut_fn, stuck0, stuck1, flip_bits, flip_mod);
   endtask

   // lag=1: the sampled value is the response to the previous vector (0 before vector 0).
   task automatic fill_pipe(input bit lag);
      for (int v = 0; v < 256; v++) begin
         int p;
         p = (lag && v > 0) ? v - 1 : (lag ? 0 : v);
         obs[v] = spec_fn(pipe_fn, 4'(p >> 4), 4'(p & 15));
      end
   endtask

   task automatic do_start(input exp_t e_in, input logic [1:0] sel, input logic vld);
      exp_t e;
      e = e_in;
      @(negedge clk);
      fn_sel = sel;
      fn_sel_valid = vld;
      case (e.inst)
         0: m_start = 1'b1;
         1: p3_start = 1'b1;
         default: p2_start = 1'b1;
      endcase
      @(posedge clk);
      #1;
      m_start = 1'b0; p3_start = 1'b0; p2_start = 1'b0;
      e.start_cyc = cyc;
      sb_q.push_back(e);
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
      check("sweep_completes", sb_q.size(), 0);
      sb_q.delete();
   endtask

   task automatic wait_vec(input logic [7:0] target, input int budget);
      int i;
      i = 0;
      while ({m_in1, m_in2} != target && i < budget) begin
         @(negedge clk);
         i++;
      end
      check("reach_vec", {m_in1, m_in2}, target);
   endtask

   task automatic run_main(input logic [1:0] dfn, input logic [3:0] s0, input logic [3:0] s1,
                           input logic [3:0] fb, input int unsigned fm,
                           input logic [1:0] sel, input logic vld);
      exp_t e;
      dut_fn = dfn; stuck0 = s0; stuck1 = s1; flip_bits = fb; flip_mod = fm;
      fill_main();
      build_exp(0, vld ? sel : 2'd0, 1, e);
      do_start(e, sel, vld);
      wait_drain(700);
   endtask

   // Monitor: pops the scoreboard whenever any checker's done rises.
   logic [2:0] done_prev = 3'b000;
   always @(negedge clk) begin
      logic [2:0]  cur, rise;
      exp_t        e;
      int unsigned a_err, a_ff, a_pass;
      cur = {p2_done, p3_done, m_done};
      rise = cur & ~done_prev;
      done_prev <= cur;
      if (rise != 3'b000) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", rise, 0);
         end else begin
            e = sb_q.pop_front();
            check("done_source", rise, 1 << e.inst);
            case (e.inst)
               0: begin a_err = m_err; a_ff = m_ff; a_pass = m_pass; end
               1: begin a_err = p3_err; a_ff = p3_ff; a_pass = p3_pass; end
               default: begin a_err = p2_err; a_ff = p2_ff; a_pass = p2_pass; end
            endcase
            check("err_count", a_err, e.err);
            check("first_fail", a_ff, e.ff);
            check("pass", a_pass, e.pass);
            check("sweep_cycles", cyc - e.start_cyc, e.cycles);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      // Asynchronous reset before any clock edge
      #1 rst_n = 1'b0;
      #2 check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", m_busy, 0);

      // Correct DUT, fn 0 via default select
      run_main(2'd0, 4'h0, 4'h0, 4'h0, 0, 2'd3, 1'b0);
      // fn 1, dut_out[0] stuck at 0
      run_main(2'd1, 4'h1, 4'h0, 4'h0, 0, 2'd1, 1'b1);
      // DUT output constantly zero, fn 0
      run_main(2'd0, 4'hF, 4'h0, 4'h0, 0, 2'd0, 1'b1);
      // fn 3 correct, explicit select
      run_main(2'd3, 4'h0, 4'h0, 4'h0, 0, 2'd3, 1'b1);

      for (int k = 0; k < 5; k++) begin
         logic [1:0]  dfn, sel;
         logic        vld;
         logic [3:0]  s0, s1, fb;
         int unsigned fm;
         dfn = 2'($urandom_range(0, 3));
         sel = 2'($urandom_range(0, 3));
         vld = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin sel = dfn; vld = 1'b1; end
         s0 = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         s1 = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         fb = 4'($urandom_range(1, 15));
         fm = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 40) : 0;
         run_main(dfn, s0, s1, fb, fm, sel, vld);
      end

      // start while busy is ignored; start in DONE restarts
      dut_fn = 2'd2; stuck0 = 4'h0; stuck1 = 4'h0; flip_mod = 0;
      fill_main();
      build_exp(0, 2'd2, 1, e);
      do_start(e, 2'd2, 1'b1);
      wait_vec(8'h80, 400);
      @(negedge clk);
      m_start = 1'b1; fn_sel = 2'd3;
      @(negedge clk);
      m_start = 1'b0;
      wait_drain(700);
      stuck1 = 4'h8;
      fill_main();
      build_exp(0, 2'd1, 1, e);
      do_start(e, 2'd1, 1'b1);
      check("restart_done_drops", m_done, 0);
      check("restart_pass_drops", m_pass, 0);
      check("restart_busy", m_busy, 1);
      wait_drain(700);

      // Reset mid-sweep with errors already counted
      dut_fn = 2'd0; stuck0 = 4'h0; stuck1 = 4'hF;
      fill_main();
      build_exp(0, 2'd0, 1, e);
      do_start(e, 2'd0, 1'b1);
      wait_vec(8'h40, 300);
      #2 rst_n = 1'b0;
      #1 check_zero("abort");
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_busy", m_busy, 0);
      check("post_reset_err", m_err, 0);
      run_main(2'd1, 4'h0, 4'h0, 4'h0, 0, 2'd1, 1'b1);

      // Slow DUT: SETTLE=3 sees settled results, SETTLE=2 sees the previous vector's
      pipe_fn = 2'($urandom_range(0, 3));
      fill_pipe(1'b0);
      build_exp(1, pipe_fn, 3, e);
      do_start(e, pipe_fn, 1'b1);
      wait_drain(1200);
      fill_pipe(1'b1);
      build_exp(2, pipe_fn, 2, e);
      do_start(e, pipe_fn, 1'b1);
      wait_drain(900);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
